// File: rtl/truth_table_sweep.sv
// truth_table_sweep: applies all 8 vectors to a 3-input block, captures its truth table and compares it to a golden copy
module truth_table_sweep #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] expected,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic [7:0] tt,
   output logic [3:0] mismatch_cnt,
   output logic       pass
);
   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
   localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);
   state_t     r_state, w_state_nxt;
   logic [2:0] r_idx, w_idx_nxt, r_abc, w_abc_nxt;
   logic [3:0] r_cnt, w_cnt_nxt, r_mis, w_mis_nxt, w_mis_smp;
   logic [7:0] r_exp, w_exp_nxt, r_tt, w_tt_nxt;
   logic       r_pass, w_pass_nxt, r_busy, r_done;
   assign w_mis_smp = r_mis + {3'b000, y != r_exp[r_idx]};
   // next state and next register values; outputs are derived from the next state so they stay registered
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_exp_nxt   = r_exp;
      w_tt_nxt    = r_tt;
      w_mis_nxt   = r_mis;
      w_pass_nxt  = r_pass;
      case (r_state)
         IDLE: if (start) begin
            w_state_nxt = SETTLE;
            w_exp_nxt   = expected;
            w_idx_nxt   = 3'd0;
            w_cnt_nxt   = 4'd0;
            w_tt_nxt    = 8'h00;
            w_mis_nxt   = 4'd0;
            w_pass_nxt  = 1'b0;
         end
         SETTLE: begin
            w_cnt_nxt   = r_cnt + 4'd1;
            w_state_nxt = (r_cnt == LAST) ? SAMPLE : SETTLE;
         end
         SAMPLE: begin
            w_tt_nxt[r_idx] = y;
            w_mis_nxt       = w_mis_smp;
            if (r_idx == 3'd7) begin
               w_state_nxt = DONE;
               w_pass_nxt  = (w_mis_smp == 4'd0);
            end else begin
               w_state_nxt = SETTLE;
               w_idx_nxt   = r_idx + 3'd1;
               w_cnt_nxt   = 4'd0;
            end
         end
         DONE: w_state_nxt = IDLE;
      endcase
      w_abc_nxt = (w_state_nxt == IDLE) ? 3'd0 : w_idx_nxt;
   end
   // state and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= 3'd0;
         r_cnt   <= 4'd0;
         r_exp   <= 8'h00;
         r_tt    <= 8'h00;
         r_mis   <= 4'd0;
         r_pass  <= 1'b0;
         r_abc   <= 3'd0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_exp   <= w_exp_nxt;
         r_tt    <= w_tt_nxt;
         r_mis   <= w_mis_nxt;
         r_pass  <= w_pass_nxt;
         r_abc   <= w_abc_nxt;
         r_busy  <= (w_state_nxt == SETTLE) || (w_state_nxt == SAMPLE);
         r_done  <= (w_state_nxt == DONE);
      end
   end
   assign {a, b, c}    = r_abc;
   assign busy         = r_busy;
   assign done         = r_done;
   assign tt           = r_tt;
   assign mismatch_cnt = r_mis;
   assign pass         = r_pass;
endmodule

// File: tb/tb_truth_table_sweep.sv
// tb_truth_table_sweep: directed sweeps against a NAND or stuck-at-0 downstream block
module tb_truth_table_sweep;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] expected = 8'h00;
   logic       y, a, b, c, busy, done, pass, y_zero = 1'b0;
   logic [7:0] tt;
   logic [3:0] mismatch_cnt;
   int         n_vec = 0, n_err = 0, lat, bad, d0, d1;
   truth_table_sweep #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .start(start), .expected(expected), .y(y),
      .a(a), .b(b), .c(c), .busy(busy), .done(done), .tt(tt),
      .mismatch_cnt(mismatch_cnt), .pass(pass)
   );
   assign y = y_zero ? 1'b0 : ~(a & b);
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic sweep(input logic [7:0] exp_v, input logic mid_start, output int l, output int nb);
      expected = exp_v;
      start = 1'b1;
      step();
      start = 1'b0;
      l = -1;
      nb = 0;
      for (int k = 0; k < 40 && l < 0; k++) begin
         if (k > 0) step();
         if (mid_start && k == 10) begin
            start = 1'b1;
            expected = 8'h00;
         end
         if (k == 11) start = 1'b0;
         if (done) l = k;
         else if ({a, b, c} != 3'(k / 3) || !busy) nb++;
      end
   endtask
   task automatic results(input string tag, input logic [7:0] t, input logic [3:0] m, input logic p);
      chk({tag, "_lat"}, lat, 24);
      chk({tag, "_seq"}, bad, 0);
      chk({tag, "_abc_done"}, {a, b, c, busy}, 4'b1110);
      chk({tag, "_tt"}, tt, t);
      chk({tag, "_mis"}, mismatch_cnt, m);
      chk({tag, "_pass"}, pass, p);
      step();
      chk({tag, "_idle"}, {a, b, c, busy, done}, 5'b00000);
      repeat (3) step();
      chk({tag, "_hold"}, {tt, mismatch_cnt, pass}, {t, m, p});
   endtask
   initial begin
      repeat (2) step();
      chk("rst_out", {a, b, c, busy, done, tt, mismatch_cnt, pass}, 0);
      start = 1'b1;
      step();
      chk("rst_prio", {busy, a, b, c}, 0);
      rst = 1'b0;
      start = 1'b0;
      step();
      sweep(8'h3F, 1'b0, lat, bad);
      results("nand", 8'h3F, 4'd0, 1'b1);
      sweep(8'h3E, 1'b0, lat, bad);
      results("nand3e", 8'h3F, 4'd1, 1'b0);
      y_zero = 1'b1;
      sweep(8'hFF, 1'b0, lat, bad);
      results("zero", 8'h00, 4'd8, 1'b0);
      y_zero = 1'b0;
      sweep(8'h3F, 1'b1, lat, bad);
      results("midstart", 8'h3F, 4'd0, 1'b1);
      expected = 8'h3F;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (13) step();
      chk("pre_rst_idx", {a, b, c}, 3'd4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst", {a, b, c, busy, done, tt, mismatch_cnt, pass}, 0);
      step();
      sweep(8'h3F, 1'b0, lat, bad);
      results("after_rst", 8'h3F, 4'd0, 1'b1);
      start = 1'b1;
      d0 = -1;
      d1 = -1;
      for (int k = 0; k < 100 && d1 < 0; k++) begin
         step();
         if (done) begin
            if (d0 < 0) d0 = k;
            else d1 = k;
         end
      end
      start = 1'b0;
      chk("b2b_seen", d1 >= 0, 1);
      chk("b2b_period", d1 - d0, 26);
      repeat (30) step();
      chk("b2b_end", {busy, tt, pass}, {1'b0, 8'h3F, 1'b1});
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
